audio_capture_dma: RTL and testbench

// - Capture-side DMA for the audio subsystem. Writes recorded samples from a capture source (I2S RX/ADC) into a ring buffer in system memory.
// - Packs incoming 16-bit samples into 32-bit words and buffers them in a FIFO.
// - Acts as an AXI4 write master (AW/W/B) and issues fixed-length INCR bursts to buf_base_i + wr_offset_o.
// - Publishes its write offset and raises an interrupt at buffer-half and buffer-wrap.

---
 rtl/audio_pkg.sv | 11 +
 rtl/audio_sync_fifo.sv | 59 +++++
 rtl/audio_capture_dma.sv | 188 ++++++++++++++++++
 tb/tb_audio_capture_dma.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared AXI encodings and DMA state type for the audio capture/playback DMA blocks.
package audio_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, AW, W, B} dma_state_e;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full are ignored,
// so the caller decides how to report the loss.
module audio_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign w_push_ok = push_i && !full_o && !flush_i;
  assign w_pop_ok  = pop_i && !empty_o && !flush_i;
  // Head is read combinationally so the W channel presents it without a bubble.
  assign head_o    = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/audio_capture_dma.sv
// Capture DMA: packs 16-bit samples into 32-bit words and writes them as
// fixed-length AXI4 INCR bursts into a ring buffer, one burst in flight.
module audio_capture_dma
  import audio_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SIZE_W     = 16,
  parameter int SAMPLE_W   = 16,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [ADDR_W-1:0]   buf_base_i,
  input  logic [SIZE_W-1:0]   buf_size_i,
  output logic [SIZE_W-1:0]   wr_offset_o,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [7:0]          awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic                overrun_o,
  output logic                error_o,
  output logic                irq_o,
  input  logic                irq_clr_i
);

  localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int SUM_W       = SIZE_W + 1;

  dma_state_e          r_state;
  logic                r_half_valid;
  logic [SAMPLE_W-1:0] r_half_data;
  logic                r_push;
  logic [DATA_W-1:0]   r_push_word;
  logic                r_awvalid, r_wvalid, r_wlast, r_bready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [SIZE_W-1:0]   r_offset;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_overrun, r_error, r_irq;

  logic                w_flush, w_pop, w_full, w_empty, w_b_done, w_irq_set;
  logic [CNT_W-1:0]    w_count;
  logic [DATA_W-1:0]   w_head;
  logic [SUM_W-1:0]    w_off_sum;
  logic [SIZE_W-1:0]   w_off_next;

  // Disabled and between bursts: discard residue and restart the ring at zero.
  assign w_flush    = (r_state == IDLE) && !enable_i;
  assign w_pop      = r_wvalid && wready_i && !w_empty;
  assign w_b_done   = (r_state == B) && bvalid_i;
  assign w_off_sum  = {1'b0, r_offset} + SUM_W'(BURST_BYTES);
  assign w_off_next = (w_off_sum >= {1'b0, buf_size_i}) ? '0 : w_off_sum[SIZE_W-1:0];
  assign w_irq_set  = w_b_done && ((w_off_next == (buf_size_i >> 1)) || (w_off_next == '0));

  audio_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (w_flush),
    .push_i      (r_push),
    .push_data_i (r_push_word),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || w_flush) begin
      r_half_valid <= 1'b0;
      r_push       <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (enable_i && sample_valid_i) begin
        r_half_valid <= !r_half_valid;
        r_push       <= r_half_valid;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enable_i && sample_valid_i) begin
      if (r_half_valid) r_push_word <= {sample_i, r_half_data};
      else              r_half_data <= sample_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_awaddr  <= '0;
      r_offset  <= '0;
      r_beat    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!enable_i) begin
            r_offset <= '0;
          end else if (w_count >= CNT_W'(BURST_LEN)) begin
            r_awaddr  <= buf_base_i + ADDR_W'(r_offset);
            r_awvalid <= 1'b1;
            r_state   <= AW;
          end
        end
        AW: begin
          if (awready_i) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (BURST_LEN == 1);
            r_beat    <= '0;
            r_state   <= W;
          end
        end
        W: begin
          if (wready_i) begin
            r_beat  <= r_beat + 1'b1;
            r_wlast <= (r_beat == BEAT_W'(BURST_LEN - 2));
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= B;
            end
          end
        end
        B: begin
          if (bvalid_i) begin
            r_bready <= 1'b0;
            r_offset <= w_off_next;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Status flags are sticky; a new event in the clear cycle still lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
      r_error   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_overrun <= (r_overrun & ~irq_clr_i) | (r_push & w_full);
      r_error   <= (r_error & ~irq_clr_i) | (w_b_done & (bresp_i != AXI_RESP_OKAY));
      r_irq     <= (r_irq & ~irq_clr_i) | w_irq_set;
    end
  end

  assign wr_offset_o    = r_offset;
  assign sample_ready_o = enable_i;
  assign awaddr_o       = r_awaddr;
  assign awlen_o        = 8'(BURST_LEN - 1);
  assign awsize_o       = 3'($clog2(DATA_W / 8));
  assign awburst_o      = AXI_BURST_INCR;
  assign awvalid_o      = r_awvalid;
  assign wdata_o        = w_head;
  assign wstrb_o        = '1;
  assign wlast_o        = r_wlast;
  assign wvalid_o       = r_wvalid;
  assign bready_o       = r_bready;
  assign overrun_o      = r_overrun;
  assign error_o        = r_error;
  assign irq_o          = r_irq;

endmodule

// File: tb/tb_audio_capture_dma.sv
// Scoreboard bench for audio_capture_dma: a sample-level model predicts
// burst addresses and beat data; a monitor checks each AXI handshake.
module tb_audio_capture_dma;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [31:0] buf_base_i = '0;
  logic [15:0] buf_size_i = 16'h0100;
  logic [15:0] wr_offset_o;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic [31:0] awaddr_o;
  logic [7:0]  awlen_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wlast_o, wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o;
  logic        overrun_o, error_o, irq_o;
  logic        irq_clr_i = 1'b0;

  always #5 clk_i = ~clk_i;

  audio_capture_dma dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .buf_base_i(buf_base_i),
    .buf_size_i(buf_size_i), .wr_offset_o(wr_offset_o), .sample_i(sample_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i), .bresp_i(bresp_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .overrun_o(overrun_o), .error_o(error_o),
    .irq_o(irq_o), .irq_clr_i(irq_clr_i)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_w[$];
  logic [31:0] exp_aw[$];
  int aw_seen = 0, w_seen = 0, b_seen = 0, w_beat = 0;
  bit aw_hold = 0;
  logic [31:0] aw_prev = '0;

  // Slave behaviour knobs
  int aw_stall = 0;
  bit w_hold = 0, w_alt = 0;
  int err_idx = -1;

  // Reference model state
  logic [15:0] m_lo;
  bit          m_has_lo = 0;
  logic [31:0] m_stage[$];
  int          m_words = 0;
  int          m_cap = 1 << 30;
  int          m_off = 0;
  int          m_size = 256;
  logic [31:0] m_base = '0;
  bit          m_irq = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sample-level model: pairs form words, words beyond FIFO capacity are lost,
  // and every 8 kept words become one burst at the next ring offset.
  function automatic void model_sample(input logic [15:0] s);
    if (!m_has_lo) begin
      m_lo = s;
      m_has_lo = 1;
    end else begin
      m_has_lo = 0;
      if (m_words < m_cap) m_stage.push_back({s, m_lo});
      m_words++;
      if (m_stage.size() == 8) begin
        exp_aw.push_back(m_base + 32'(m_off));
        repeat (8) exp_w.push_back(m_stage.pop_front());
        m_off = (m_off + 32 >= m_size) ? 0 : m_off + 32;
        if (m_off == m_size / 2 || m_off == 0) m_irq = 1;
      end
    end
  endfunction

  // Monitor: compare every AXI handshake against the scoreboard queues.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (awvalid_o) begin
        if (aw_hold) check("awaddr_stable", awaddr_o, aw_prev);
        aw_hold = !awready_i;
        aw_prev = awaddr_o;
      end else begin
        aw_hold = 0;
      end
      if (awvalid_o && awready_i) begin
        if (exp_aw.size() == 0) begin
          checks++; failures++;
          $display("FAIL aw_unexpected actual=%0h required=none", awaddr_o);
        end else begin
          check("awaddr", awaddr_o, exp_aw.pop_front());
        end
        check("aw_len_size_burst", {awlen_o, awsize_o, awburst_o}, {8'd7, 3'd2, 2'd1});
        aw_seen++;
      end
      if (wvalid_o && wready_i) begin
        if (exp_w.size() == 0) begin
          checks++; failures++;
          $display("FAIL w_unexpected actual=%0h required=none", wdata_o);
        end else begin
          check("wdata", wdata_o, exp_w.pop_front());
        end
        check("wlast", wlast_o, 64'((w_beat % 8) == 7));
        check("wstrb", wstrb_o, 4'hF);
        $display("beat %0d data=%08h last=%0b", w_beat, wdata_o, wlast_o);
        w_beat++;
        w_seen++;
      end
      if (bvalid_i && bready_o) b_seen++;
    end
  end

  // AXI slave responder
  initial begin : slave
    int stall_cnt;
    bit tog;
    stall_cnt = 0;
    tog = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 2'b00;
    forever begin
      @(posedge clk_i); #1;
      if (awvalid_o && !awready_i) begin
        if (stall_cnt >= aw_stall) awready_i = 1;
        else stall_cnt++;
      end else begin
        awready_i = 0;
        stall_cnt = 0;
      end
      if (w_hold) wready_i = 0;
      else if (w_alt) begin wready_i = tog; tog = ~tog; end
      else wready_i = 1;
      if (bready_o && !bvalid_i) begin
        bvalid_i = 1;
        bresp_i = (b_seen == err_idx) ? 2'b10 : 2'b00;
      end else begin
        bvalid_i = 0;
        bresp_i = 2'b00;
      end
    end
  end

  task automatic do_reset(input logic [31:0] base, input logic [15:0] size);
    @(negedge clk_i);
    rst_i = 1; enable_i = 0; sample_valid_i = 0; irq_clr_i = 0;
    repeat (2) @(negedge clk_i);
    exp_w.delete(); exp_aw.delete(); m_stage.delete();
    aw_seen = 0; w_seen = 0; b_seen = 0; w_beat = 0; aw_hold = 0;
    aw_stall = 0; w_hold = 0; w_alt = 0; err_idx = -1;
    m_has_lo = 0; m_words = 0; m_cap = 1 << 30; m_off = 0; m_irq = 0;
    buf_base_i = base; buf_size_i = size; m_base = base; m_size = int'(size);
    check("reset_state", {awvalid_o, wvalid_o, wlast_o, bready_o, overrun_o, error_o, irq_o, wr_offset_o}, '0);
    rst_i = 0;
  endtask

  task automatic feed(input int n, input bit ramp, input logic [15:0] start, input bit gaps);
    for (int i = 0; i < n; i++) begin
      logic [15:0] s;
      s = ramp ? start + 16'(i) : 16'($urandom);
      @(posedge clk_i); #1;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        sample_valid_i = 0;
        @(posedge clk_i); #1;
      end
      sample_i = s;
      sample_valid_i = 1;
      model_sample(s);
    end
    @(posedge clk_i); #1;
    sample_valid_i = 0;
  endtask

  task automatic wait_cnt(input int which, input int target, input string name);
    int cyc;
    int cur;
    cyc = 0;
    cur = (which == 0) ? w_seen : b_seen;
    while (cur < target && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      cur = (which == 0) ? w_seen : b_seen;
    end
    check(name, cur, target);
  endtask

  task automatic clear_irq();
    @(negedge clk_i); irq_clr_i = 1;
    @(negedge clk_i); irq_clr_i = 0;
    m_irq = 0;
  endtask

  initial begin : main
    int cyc;

    // 1. Basic burst with a ramp
    do_reset(32'h1000_0000, 16'h0100);
    enable_i = 1;
    @(negedge clk_i);
    check("sample_ready", sample_ready_o, enable_i);
    feed(16, 1, 16'h0001, 0);
    wait_cnt(1, 1, "t1_bursts");
    check("t1_drained", exp_w.size(), 0);
    check("t1_offset", wr_offset_o, m_off);
    check("t1_irq", irq_o, m_irq);

    // 2. Ring wrap: half, wrap, half again
    do_reset(32'h2000_0400, 16'h0040);
    enable_i = 1;
    for (int k = 1; k <= 3; k++) begin
      feed(16, 0, 16'h0, 1);
      wait_cnt(1, k, "t2_bursts");
      check("t2_offset", wr_offset_o, m_off);
      check("t2_irq_set", irq_o, m_irq);
      clear_irq();
      @(negedge clk_i);
      check("t2_irq_clr", irq_o, m_irq);
    end

    // 3. Backpressure on AW and W
    do_reset(32'h3000_0000, 16'h0100);
    aw_stall = 10; w_alt = 1; enable_i = 1;
    feed(64, 1, 16'h0100, 0);
    wait_cnt(1, 4, "t3_bursts");
    check("t3_drained", exp_w.size(), 0);
    check("t3_overrun", overrun_o, 0);
    check("t3_offset", wr_offset_o, m_off);
    check("t3_irq", irq_o, m_irq);

    // 4. Overrun: W stalled while 66 words arrive into a 64-deep FIFO
    do_reset(32'h4000_0000, 16'h0200);
    w_hold = 1; m_cap = 64; enable_i = 1;
    feed(132, 0, 16'h0, 0);
    repeat (4) @(negedge clk_i);
    check("t4_overrun", overrun_o, 1);
    w_hold = 0;
    wait_cnt(1, 8, "t4_bursts");
    repeat (20) @(negedge clk_i);
    check("t4_no_extra_aw", aw_seen, 8);
    check("t4_drained", exp_w.size(), 0);
    check("t4_offset", wr_offset_o, m_off);

    // 5. Error response still advances the offset
    do_reset(32'h5000_0000, 16'h0040);
    err_idx = 0; enable_i = 1;
    feed(16, 0, 16'h0, 1);
    wait_cnt(1, 1, "t5_bursts");
    check("t5_error", error_o, 1);
    check("t5_offset", wr_offset_o, m_off);
    check("t5_irq", irq_o, m_irq);
    clear_irq();
    @(negedge clk_i);
    check("t5_flags_clr", {error_o, overrun_o, irq_o}, 3'b000);

    // 6. Disable at beat 3: burst completes, residue flushed, offset rewinds
    do_reset(32'h6000_0000, 16'h0100);
    w_hold = 1; enable_i = 1;
    feed(24, 0, 16'h0, 0);
    w_hold = 0;
    wait_cnt(0, 3, "t6_beat3");
    enable_i = 0;
    m_stage.delete(); m_has_lo = 0; m_off = 0;
    wait_cnt(1, 1, "t6_bursts");
    repeat (20) @(negedge clk_i);
    check("t6_single_aw", aw_seen, 1);
    check("t6_beats", w_seen, 8);
    check("t6_offset", wr_offset_o, m_off);
    enable_i = 1;
    feed(16, 0, 16'h0, 0);
    wait_cnt(1, 2, "t6_reenable");
    check("t6_offset2", wr_offset_o, m_off);

    // Reset in the middle of the W phase
    w_hold = 1;
    feed(16, 0, 16'h0, 0);
    cyc = 0;
    while (!wvalid_o && cyc < 200) begin @(negedge clk_i); cyc++; end
    check("t7_reach_w", wvalid_o, 1);
    rst_i = 1;
    @(negedge clk_i);
    check("t7_rst_outputs", {awvalid_o, wvalid_o, wlast_o, bready_o, overrun_o, error_o, irq_o, wr_offset_o}, '0);
    do_reset(32'h0, 16'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
